// File: rtl/sumsq_pkg.sv
// Shared types for the sum-of-squares issue stage.
// State encoding and radicand width helper.
package sumsq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    ISSUE
  } state_t;

  function automatic int rad_w(input int in_w);
    return 2 * in_w + 2;
  endfunction

endpackage

// File: rtl/sumsq_issue_serial_sq_step.sv
// One shift-add multiply iteration, shared by both squares.
// Pure combinational: next mcand/mplr/acc from current ones.
module serial_sq_step #(
  parameter int IN_W  = 4,
  parameter int RAD_W = 10
) (
  input  logic [RAD_W-1:0] mcand,
  input  logic [IN_W-1:0]  mplr,
  input  logic [RAD_W-1:0] acc,
  output logic [RAD_W-1:0] mcand_n,
  output logic [IN_W-1:0]  mplr_n,
  output logic [RAD_W-1:0] acc_n
);

  // Conditional add of the multiplicand, then shift both operands.
  always_comb begin
    acc_n   = mplr[0] ? acc + mcand : acc;
    mcand_n = mcand << 1;
    mplr_n  = mplr >> 1;
  end

endmodule

// File: rtl/sumsq_issue.sv
// Computes x*x + y*y serially and issues it to the sqrt core.
// SUMSQ_SIGNED_EN: treat in_x/in_y as two's complement.
module sumsq_issue
  import sumsq_pkg::*;
#(
  parameter int IN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_x,
  input  logic [IN_W-1:0]         in_y,
  input  logic                    sq_busy,
  output logic                    sq_start,
  output logic [rad_w(IN_W)-1:0]  sq_rad
);

  localparam int RAD_W = rad_w(IN_W);
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [RAD_W-1:0]   acc;
  logic [RAD_W-1:0]   mcand;
  logic [IN_W-1:0]    mplr;
  logic [IN_W-1:0]    y_mag;
  logic [RAD_W-1:0]   rad_q;
  logic [RAD_W-1:0]   acc_n;
  logic [RAD_W-1:0]   mcand_n;
  logic [IN_W-1:0]    mplr_n;

`ifdef SUMSQ_SIGNED_EN
  function automatic logic [IN_W-1:0] mag(
    input logic [IN_W-1:0] v
  );
    return v[IN_W-1] ? -v : v;
  endfunction
`else
  function automatic logic [IN_W-1:0] mag(
    input logic [IN_W-1:0] v
  );
    return v;
  endfunction
`endif

  serial_sq_step #(
    .IN_W  (IN_W),
    .RAD_W (RAD_W)
  ) u_step (
    .mcand   (mcand),
    .mplr    (mplr),
    .acc     (acc),
    .mcand_n (mcand_n),
    .mplr_n  (mplr_n),
    .acc_n   (acc_n)
  );

  assign last = (cnt == CNT_W'(IN_W - 1));

  // Start cycle exposes the final sum directly, then the held copy.
  assign sq_rad = sq_start ? acc : rad_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    sq_start = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = MUL_X;
      end
      MUL_X: begin
        if (last) state_n = MUL_Y;
      end
      MUL_Y: begin
        if (last) state_n = ISSUE;
      end
      ISSUE: begin
        sq_start = !sq_busy;
        if (!sq_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand load, shift-add iterations and radicand hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      y_mag <= '0;
      cnt   <= '0;
      rad_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= RAD_W'(mag(in_x));
            mplr  <= mag(in_x);
            y_mag <= mag(in_y);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL_X: begin
          acc <= acc_n;
          if (last) begin
            mcand <= RAD_W'(y_mag);
            mplr  <= y_mag;
            cnt   <= '0;
          end else begin
            mcand <= mcand_n;
            mplr  <= mplr_n;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        MUL_Y: begin
          acc   <= acc_n;
          mcand <= mcand_n;
          mplr  <= mplr_n;
          cnt   <= last ? '0 : cnt + CNT_W'(1);
        end
        ISSUE: begin
          if (sq_start) rad_q <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule
